// File: rtl/cpu_control_unit.sv
// cpu_control_unit
//   Multi-cycle sequencer for the CPU data path. It fetches an instruction
//   word from the shared bus into IR. It decodes the instruction class. It
//   then steps the data path through the address, execute, memory and
//   write-back phases. Memory transfers are bounded by a wait counter. A
//   timeout halts the core and sets bus_err.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   Valid               memory completion strobe (used only in FWAIT/MWAIT)
//   instr_in [WIDTH]    data bus; captured into IR when a fetch completes
//   mem_rd, mem_wr      memory read / write requests
//   fetch .. regEn      one-bit data path controls
//   oppA, oppB          register fields IR[25:21], IR[20:16]
//   opcode              IR[31:26], overridden in the store-data and branch phases
//   literal [WIDTH]     sign-extended IR[15:0]
//   halted, bus_err     core stopped / stopped because of a memory timeout
module cpu_control_unit #(
  parameter int          WIDTH      = 32,
  parameter int          WAIT_LIMIT = 255,
  parameter logic [5:0]  PASS_OP    = 6'b001111,
  parameter logic [5:0]  ADD_OP     = 6'b000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] instr_in,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             fetch,
  output logic             Addreg_wr_En,
  output logic             increment,
  output logic             PC_wr_En,
  output logic             Branch_En,
  output logic             literalEn,
  output logic             store_en,
  output logic             Datareg_wr_En,
  output logic             DataBus_En,
  output logic             store_PC,
  output logic             regEn,
  output logic [4:0]       oppA,
  output logic [4:0]       oppB,
  output logic [5:0]       opcode,
  output logic [WIDTH-1:0] literal,
  output logic             halted,
  output logic             bus_err
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    ST_FADDR, ST_FWAIT, ST_DEC, ST_EXEC, ST_MADDR,
    ST_DATA, ST_MWAIT, ST_WB, ST_HALT
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] ir_reg;
  logic [CW-1:0]    wait_cnt_reg;
  logic             bus_err_reg;

  // Instruction class decode from the latched IR.
  logic is_mem, is_load, is_store, is_branch, is_halt, is_alu_lit;
  assign is_mem     = (ir_reg[31:30] == 2'b10);
  assign is_load    = is_mem & ~ir_reg[26];
  assign is_store   = is_mem &  ir_reg[26];
  assign is_branch  = (ir_reg[31:30] == 2'b11) & ~ir_reg[26];
  // Every class-11 encoding that is not a branch stops the core.
  assign is_halt    = (ir_reg[31:30] == 2'b11) &  ir_reg[26];
  assign is_alu_lit = (ir_reg[31:30] == 2'b01);

  // The wait budget ends on the WAIT_LIMIT-th cycle spent waiting.
  // A Valid in that same cycle still completes the transfer.
  logic wait_expired;
  assign wait_expired = ~Valid & (wait_cnt_reg == LAST_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_FADDR;
      ir_reg       <= '0;
      wait_cnt_reg <= '0;
      bus_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_FADDR: begin
          wait_cnt_reg <= '0;
          state_reg    <= ST_FWAIT;
        end
        ST_FWAIT: begin
          if (Valid) begin
            ir_reg    <= instr_in;
            state_reg <= ST_DEC;
          end else if (wait_expired) begin
            bus_err_reg <= 1'b1;
            state_reg   <= ST_HALT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        ST_DEC: begin
          if (is_halt)     state_reg <= ST_HALT;
          else if (is_mem) state_reg <= ST_MADDR;
          else             state_reg <= ST_EXEC;
        end
        ST_EXEC:  state_reg <= ST_WB;
        ST_MADDR: begin
          wait_cnt_reg <= '0;
          state_reg    <= is_store ? ST_DATA : ST_MWAIT;
        end
        ST_DATA: begin
          wait_cnt_reg <= '0;
          state_reg    <= ST_MWAIT;
        end
        ST_MWAIT: begin
          if (Valid) begin
            state_reg <= is_load ? ST_WB : ST_FADDR;
          end else if (wait_expired) begin
            bus_err_reg <= 1'b1;
            state_reg   <= ST_HALT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        ST_WB:    state_reg <= ST_FADDR;
        ST_HALT:  state_reg <= ST_HALT;
        default:  state_reg <= ST_HALT;
      endcase
    end
  end

  assign bus_err = bus_err_reg;
  assign literal = {{(WIDTH-16){ir_reg[15]}}, ir_reg[15:0]};

  // Controls are decoded from the state register. While reset is high they
  // are held at 0. This drops mem_rd/mem_wr without waiting for a clock edge.
  always_comb begin
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    fetch         = 1'b0;
    Addreg_wr_En  = 1'b0;
    increment     = 1'b0;
    PC_wr_En      = 1'b0;
    Branch_En     = 1'b0;
    literalEn     = 1'b0;
    store_en      = 1'b0;
    Datareg_wr_En = 1'b0;
    DataBus_En    = 1'b0;
    store_PC      = 1'b0;
    regEn         = 1'b0;
    halted        = 1'b0;
    oppA          = ir_reg[25:21];
    oppB          = ir_reg[20:16];
    opcode        = ir_reg[31:26];
    if (!reset) begin
      case (state_reg)
        ST_FADDR: begin
          fetch        = 1'b1;
          Addreg_wr_En = 1'b1;
        end
        ST_FWAIT: mem_rd = 1'b1;
        ST_DEC:   increment = 1'b1;
        ST_EXEC: begin
          Datareg_wr_En = 1'b1;
          literalEn     = is_alu_lit | is_branch;
          if (is_branch) begin
            Branch_En = 1'b1;
            opcode    = ADD_OP;
          end
        end
        ST_MADDR: begin
          literalEn    = 1'b1;
          Addreg_wr_En = 1'b1;
        end
        ST_DATA: begin
          // The data register of a store is IR[20:16]. It is routed through
          // oppA so the ALU passes it into dataR.
          opcode        = PASS_OP;
          Datareg_wr_En = 1'b1;
          oppA          = ir_reg[20:16];
        end
        ST_MWAIT: begin
          if (is_load) begin
            mem_rd        = 1'b1;
            store_en      = Valid;
            Datareg_wr_En = Valid;
          end else begin
            mem_wr     = 1'b1;
            DataBus_En = 1'b1;
          end
        end
        ST_WB: begin
          if (is_branch) PC_wr_En = 1'b1;
          else           regEn    = 1'b1;
        end
        ST_HALT: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule
